// File: rtl/regheap_drain_64x16b.sv
// ============================================================================
// Module   : regheap_drain_64x16b
// Purpose  : Ping-pong drain stage: captures 1024-bit heap vectors and streams
//            each as 16 beats of 64 bits over valid/ready. Optional output
//            ReLU on each 16-bit lane under macro REGHEAP_DRAIN_RELU_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regheap_drain_64x16b (
   input  logic          clk,
   input  logic          rst,
   input  logic          data_v,
   input  logic [1023:0] in_data,
   input  logic          flush,
   input  logic          out_rdy,
   output logic          out_v,
   output logic [63:0]   out_data,
   output logic          out_last,
   output logic          need_data,
   output logic          ovf
);

   localparam logic [3:0] c_LAST_BEAT = 4'd15;
   localparam logic [1:0] c_FULL      = 2'd2;

   logic [1023:0] r_entry0;
   logic [1023:0] r_entry1;
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic [1:0]    r_count;
   logic [3:0]    r_beat;
   logic          r_ovf;

   logic          w_out_v;
   logic          w_beat_last;
   logic          w_adv;
   logic          w_drain_done;
   logic          w_take;
   logic          w_drop;
   logic [1023:0] w_rd_entry;
   logic [63:0]   w_beat_raw;
   logic [63:0]   w_beat_lane;

   always_comb begin
      w_out_v      = (r_count != 2'd0);
      w_beat_last  = (r_beat == c_LAST_BEAT);
      w_adv        = w_out_v && out_rdy;
      w_drain_done = w_adv && w_beat_last;
      // A full buffer still takes a vector when its oldest entry finishes draining this cycle.
      w_take       = data_v && !flush && ((r_count != c_FULL) || w_drain_done);
      w_drop       = data_v && !flush && !w_take;
      w_rd_entry   = r_rd_ptr ? r_entry1 : r_entry0;
      w_beat_raw   = w_rd_entry[{r_beat, 6'b000000} +: 64];
   end

   for (genvar k = 0; k < 4; k++) begin : g_lane
`ifdef REGHEAP_DRAIN_RELU_EN
      assign w_beat_lane[k*16 +: 16] = w_beat_raw[k*16 + 15] ? 16'h0000
                                                               : w_beat_raw[k*16 +: 16];
`else
      assign w_beat_lane[k*16 +: 16] = w_beat_raw[k*16 +: 16];
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_entry0 <= '0;
         r_entry1 <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_beat   <= 4'd0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
         if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_beat   <= 4'd0;
         end else begin
            if (w_take) begin
               if (r_wr_ptr) begin
                  r_entry1 <= in_data;
               end else begin
                  r_entry0 <= in_data;
               end
               r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_adv) begin
               r_beat <= r_beat + 4'd1;
               if (w_beat_last) begin
                  r_rd_ptr <= ~r_rd_ptr;
               end
            end
            case ({w_take, w_drain_done})
               2'b10:   r_count <= r_count + 2'd1;
               2'b01:   r_count <= r_count - 2'd1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_comb begin
      out_v     = w_out_v;
      out_data  = w_out_v ? w_beat_lane : 64'd0;
      out_last  = w_out_v && w_beat_last;
      need_data = (r_count != c_FULL);
      ovf       = r_ovf;
   end

endmodule

`default_nettype wire

// File: tb/tb_regheap_drain_64x16b.sv
// ============================================================================
// Module   : tb_regheap_drain_64x16b
// Purpose  : Self-checking bench for regheap_drain_64x16b against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regheap_drain_64x16b;

   logic          clk = 1'b0;
   logic          rst;
   logic          data_v;
   logic [1023:0] in_data;
   logic          flush;
   logic          out_rdy;
   logic          out_v;
   logic [63:0]   out_data;
   logic          out_last;
   logic          need_data;
   logic          ovf;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   regheap_drain_64x16b dut (
      .clk       (clk),
      .rst       (rst),
      .data_v    (data_v),
      .in_data   (in_data),
      .flush     (flush),
      .out_rdy   (out_rdy),
      .out_v     (out_v),
      .out_data  (out_data),
      .out_last  (out_last),
      .need_data (need_data),
      .ovf       (ovf)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: FIFO of at most two vectors plus index of the beat on display
   logic [1023:0] mq[$];
   int            mbeat = 0;
   bit            movf  = 1'b0;

   always @(posedge clk) begin
      bit adv;
      if (rst) begin
         mq.delete();
         mbeat = 0;
         movf  = 1'b0;
      end else if (flush) begin
         mq.delete();
         mbeat = 0;
      end else begin
         adv = (mq.size() != 0) && out_rdy;
         if (adv) begin
            if (mbeat == 15) begin
               void'(mq.pop_front());
               mbeat = 0;
            end else begin
               mbeat++;
            end
         end
         if (data_v) begin
            if (mq.size() < 2) mq.push_back(in_data);
            else               movf = 1'b1;
         end
      end
   end

   function automatic logic [63:0] relu4(input logic [63:0] w);
      logic [63:0] r;
      r = w;
`ifdef REGHEAP_DRAIN_RELU_EN
      for (int j = 0; j < 4; j++) begin
         if (w[16*j+15]) r[16*j +: 16] = 16'h0000;
      end
`endif
      return r;
   endfunction

   function automatic logic [63:0] m_data();
      logic [1023:0] v;
      if (mq.size() == 0) return 64'd0;
      v = mq[0];
      return relu4(v[mbeat*64 +: 64]);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_v",     {63'd0, out_v},     {63'd0, mq.size() != 0});
         chk("out_data",  out_data,           m_data());
         chk("out_last",  {63'd0, out_last},  {63'd0, (mq.size() != 0) && (mbeat == 15)});
         chk("need_data", {63'd0, need_data}, {63'd0, mq.size() < 2});
         chk("ovf",       {63'd0, ovf},       {63'd0, movf});
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [1023:0] rand_vec();
      logic [1023:0] v;
      for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   task automatic push(input logic [1023:0] v);
      data_v  = 1'b1;
      in_data = v;
      tick();
      data_v  = 1'b0;
   endtask

   // Fill both entries with out_rdy low, overflow with a third, then drain A to beat 7
   task automatic fill_ovf_to_beat7();
      out_rdy = 1'b0;
      push(rand_vec());
      push(rand_vec());
      push(rand_vec());
      chk("pre_ovf", {63'd0, ovf}, 64'd1);
      out_rdy = 1'b1;
      repeat (7) tick();
      chk("pre_beat7", 64'(mbeat), 64'd7);
   endtask

   logic [1023:0] vec;
   logic [1023:0] vb;
   int            k;

   initial begin
      rst = 1'b1; data_v = 1'b0; in_data = '0; flush = 1'b0; out_rdy = 1'b0;
      tick(); tick();
      chk_en = 1'b1;
      chk("rst_out_v",     {63'd0, out_v},     64'd0);
      chk("rst_out_data",  out_data,           64'd0);
      chk("rst_need_data", {63'd0, need_data}, 64'd1);
      chk("rst_ovf",       {63'd0, ovf},       64'd0);
      rst = 1'b0;
      tick();

      // Single vector, lane i = i
      for (int i = 0; i < 64; i++) vec[16*i +: 16] = 16'(i);
      out_rdy = 1'b1;
      push(vec);
      chk("t1_beat0", out_data, 64'h0003_0002_0001_0000);
      chk("t1_v0",    {63'd0, out_v}, 64'd1);
      repeat (15) tick();
      chk("t1_beat15", out_data, 64'h003F_003E_003D_003C);
      chk("t1_last",   {63'd0, out_last}, 64'd1);
      tick();
      chk("t1_done", {63'd0, out_v}, 64'd0);

      // Backpressure pattern 1,0,0,1
      out_rdy = 1'b1;
      push(vec);
      for (int i = 0; i < 64; i++) begin
         out_rdy = ((i % 4) == 0) || ((i % 4) == 3);
         tick();
      end
      out_rdy = 1'b1;
      repeat (20) tick();
      chk("t2_done", {63'd0, out_v}, 64'd0);

      // Overflow
      out_rdy = 1'b0;
      push(rand_vec());
      vb = rand_vec();
      push(vb);
      chk("t3_need0", {63'd0, need_data}, 64'd0);
      push(rand_vec());
      chk("t3_ovf", {63'd0, ovf}, 64'd1);
      out_rdy = 1'b1;
      repeat (40) tick();
      chk("t3_done", {63'd0, out_v}, 64'd0);
      rst = 1'b1; tick(); rst = 1'b0; tick();

      // Full buffer with third vector on the last-beat handshake
      out_rdy = 1'b1;
      push(rand_vec());
      vb = rand_vec();
      push(vb);
      k = 0;
      while (!(mbeat == 15 && mq.size() == 2) && k < 40) begin
         tick();
         k++;
      end
      if (k >= 40) begin
         n_cmp++; n_err++;
         $display("FAIL t4_wait: got timeout expected beat 15 with two entries");
      end
      push(rand_vec());
      chk("t4_ovf",   {63'd0, ovf},       64'd0);
      chk("t4_need",  {63'd0, need_data}, 64'd0);
      chk("t4_nextB", out_data,           relu4(vb[63:0]));
      repeat (40) tick();
      chk("t4_done", {63'd0, out_v}, 64'd0);

      // Flush at beat 7 together with data_v
      fill_ovf_to_beat7();
      flush = 1'b1; data_v = 1'b1; in_data = rand_vec();
      tick();
      flush = 1'b0; data_v = 1'b0;
      chk("t5_flush_v",    {63'd0, out_v},     64'd0);
      chk("t5_flush_ovf",  {63'd0, ovf},       64'd1);
      chk("t5_flush_need", {63'd0, need_data}, 64'd1);
      repeat (3) tick();

      // Same with reset
      fill_ovf_to_beat7();
      rst = 1'b1; data_v = 1'b1; in_data = rand_vec();
      tick();
      rst = 1'b0; data_v = 1'b0;
      chk("t5_rst_v",    {63'd0, out_v},     64'd0);
      chk("t5_rst_data", out_data,           64'd0);
      chk("t5_rst_last", {63'd0, out_last},  64'd0);
      chk("t5_rst_need", {63'd0, need_data}, 64'd1);
      chk("t5_rst_ovf",  {63'd0, ovf},       64'd0);
      tick();

      // Sign-alternating lanes
      for (int i = 0; i < 64; i++) vec[16*i +: 16] = (i % 2 == 0) ? 16'h8001 : 16'h7FFF;
      out_rdy = 1'b1;
      push(vec);
`ifdef REGHEAP_DRAIN_RELU_EN
      chk("t6_relu", out_data, 64'h7FFF_0000_7FFF_0000);
`else
      chk("t6_relu", out_data, 64'h7FFF_8001_7FFF_8001);
`endif
      repeat (20) tick();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         data_v  = ($urandom % 4) == 0;
         in_data = rand_vec();
         out_rdy = ($urandom % 3) != 0;
         flush   = ($urandom % 97) == 0;
         rst     = ($urandom % 499) == 0;
         tick();
      end
      data_v = 1'b0; flush = 1'b0; rst = 1'b0; out_rdy = 1'b1;
      repeat (40) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
